// File: rtl/uart_tx_engine.sv
// UART transmit engine: byte FIFO feeding a one-hot framing FSM.
// Start, 8 data bits, optional parity and one stop bit, paced by BaudSig_i.
module uart_tx_engine #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               Data_i,
  input  logic                     n_We_i,
  input  logic                     n_Clr_i,
  input  logic                     p_Enable_i,
  input  logic                     p_ParityEnable_i,
  input  logic                     ParityMethod_i,
  input  logic                     p_BigEnd_i,
  input  logic                     BaudSig_i,
  output logic                     Tx_o,
  output logic [4:0]               State_o,
  output logic                     p_Busy_o,
  output logic                     p_Empty_o,
  output logic                     p_Full_o,
  output logic                     p_Over_o,
  output logic [$clog2(DEPTH):0]   TxFifoLevel_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    STARTBIT  = 5'b00010,
    DATABITS  = 5'b00100,
    PARITYBIT = 5'b01000,
    STOPBIT   = 5'b10000
  } state_t;

  state_t state, nextState;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [LW-1:0] level;
  logic          over;

  logic [7:0] shiftReg;
  logic [2:0] bitCnt, nextCnt;
  logic       parEn, parBit, bigEnd;
  logic       pop, canStart, wrAcc;
  logic       txNext;
  logic [2:0] bitIdx;
  logic [7:0] popData;

  assign p_Empty_o     = (level == '0);
  assign p_Full_o      = (level == LW'(DEPTH));
  assign p_Over_o      = over;
  assign TxFifoLevel_o = level;
  assign State_o       = state;

  // A flush blocks both the enqueue and the dequeue in its cycle.
  assign wrAcc    = !n_We_i && !p_Full_o && n_Clr_i;
  assign canStart = p_Enable_i && !p_Empty_o && n_Clr_i;
  assign popData  = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (wrAcc) mem[wrPtr] <= Data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
      over  <= 1'b0;
    end else if (!n_Clr_i) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
      over  <= 1'b0;
    end else begin
      if (wrAcc) wrPtr <= wrPtr + AW'(1);
      if (pop)   rdPtr <= rdPtr + AW'(1);
      level <= level + LW'(wrAcc) - LW'(pop);
      if (!n_We_i && p_Full_o) over <= 1'b1;
    end
  end

  // Frame configuration is captured with the byte so mid-frame edits are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shiftReg <= '0;
      parEn    <= 1'b0;
      parBit   <= 1'b0;
      bigEnd   <= 1'b0;
    end else if (pop) begin
      shiftReg <= popData;
      parEn    <= p_ParityEnable_i;
      parBit   <= (^popData) ^ ParityMethod_i;
      bigEnd   <= p_BigEnd_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      bitCnt <= '0;
      Tx_o   <= 1'b1;
    end else begin
      state  <= nextState;
      bitCnt <= nextCnt;
      Tx_o   <= txNext;
    end
  end

  always_comb begin
    nextState = state;
    nextCnt   = bitCnt;
    pop       = 1'b0;
    if (BaudSig_i) begin
      unique case (state)
        IDLE: begin
          if (canStart) begin
            nextState = STARTBIT;
            pop       = 1'b1;
          end
        end
        STARTBIT: begin
          nextState = DATABITS;
          nextCnt   = '0;
        end
        DATABITS: begin
          if (bitCnt == 3'd7)
            nextState = parEn ? PARITYBIT : STOPBIT;
          else
            nextCnt = bitCnt + 3'd1;
        end
        PARITYBIT: nextState = STOPBIT;
        STOPBIT: begin
          if (canStart) begin
            nextState = STARTBIT;
            pop       = 1'b1;
          end else begin
            nextState = IDLE;
          end
        end
        default: nextState = IDLE;
      endcase
    end
  end

  always_comb begin
    bitIdx   = bigEnd ? (3'd7 - nextCnt) : nextCnt;
    txNext   = 1'b1;
    p_Busy_o = (state != IDLE);
    unique case (1'b1)
      nextState[1]: txNext = 1'b0;
      nextState[2]: txNext = shiftReg[bitIdx];
      nextState[3]: txNext = parBit;
      default:      txNext = 1'b1;
    endcase
  end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the transmit FIFO depth in bytes (power of two, 4..256).
REQ-002 The block SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port Data_i  input  8  byte to enqueue.
REQ-005 The block SHALL have port n_We_i  input  1  active-low FIFO write strobe, 1 clk per byte.
REQ-006 The block SHALL have port n_Clr_i  input  1  active-low FIFO flush.
REQ-007 The block SHALL have port p_Enable_i  input  1  high permits new frames to start.
REQ-008 The block SHALL have port p_ParityEnable_i  input  1  high inserts a parity bit.
REQ-009 The block SHALL have port ParityMethod_i  input  1  0 even, 1 odd.
REQ-010 The block SHALL have port p_BigEnd_i  input  1  1 sends bit7 first, 0 sends bit0 first.
REQ-011 The block SHALL have port BaudSig_i  input  1  1-clk pulse marking each bit boundary.
REQ-012 The block SHALL have port Tx_o  output  1  serial line, idle high, registered.
REQ-013 The block SHALL have port State_o  output  5  one-hot FSM state.
REQ-014 The block SHALL have port p_Busy_o  output  1  high when State_o is not IDLE.
REQ-015 The block SHALL have port p_Empty_o / p_Full_o / p_Over_o  output  1 each  FIFO empty, full, sticky overflow.
REQ-016 The block SHALL have port TxFifoLevel_o  output  log2(DEPTH)+1  bytes held in FIFO.

Function
REQ-017 FSM states SHALL be IDLE 5'b00001, STARTBIT 5'b00010, DATABITS 5'b00100, PARITYBIT 5'b01000, STOPBIT 5'b10000.
REQ-018 IDLE -> STARTBIT SHALL occur on a BaudSig_i cycle with p_Enable_i=1 and FIFO non-empty; that cycle pops one byte and latches p_ParityEnable_i, ParityMethod_i and p_BigEnd_i for the frame.
REQ-019 Tx_o SHALL take each state's line value on the clk after the BaudSig_i that enters the state: STARTBIT 0, DATABITS the data bits, PARITYBIT the parity bit, STOPBIT 1, IDLE 1.
REQ-020 DATABITS SHALL last exactly 8 BaudSig_i pulses, with one bit per pulse in the order selected by the latched p_BigEnd_i.
REQ-021 After the 8th data bit, the next BaudSig_i SHALL enter PARITYBIT if latched parity is enabled, otherwise STOPBIT.
REQ-022 The parity bit SHALL equal XOR of the 8 data bits for even parity and its inverse for odd parity.
REQ-023 STOPBIT SHALL last one baud period; at its terminating BaudSig_i the FSM SHALL go to STARTBIT (popping the next byte, back-to-back, no idle gap) if p_Enable_i=1 and FIFO non-empty, else to IDLE.
REQ-024 Changes to configuration inputs mid-frame SHALL NOT affect the frame in progress.
REQ-025 Deasserting p_Enable_i mid-frame SHALL let the current frame complete; no new frame starts.
REQ-026 BaudSig_i SHALL be ignored by the FSM in all other cycles; the state is held between pulses.
REQ-027 A write with n_We_i=0 and FIFO not full SHALL store Data_i and increment the level on the next clk.
REQ-028 A write when p_Full_o=1 SHALL drop the byte and set p_Over_o; this applies even if a pop occurs in the same cycle.
REQ-029 A simultaneous accepted write and pop SHALL leave the level unchanged and keep byte order.
REQ-030 n_Clr_i=0 SHALL empty the FIFO (level 0) and clear p_Over_o on the next clk.
REQ-031 n_Clr_i=0 SHALL win over a same-cycle write (the byte is dropped, p_Over_o is not set) and over a same-cycle pop (no frame starts); a frame already in progress SHALL complete from its shift register.
REQ-032 p_Empty_o SHALL equal (level==0) and p_Full_o SHALL equal (level==DEPTH); both are registered-consistent with TxFifoLevel_o.
REQ-033 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-034 While rst=0 the block SHALL hold: Tx_o=1, State_o=IDLE, p_Busy_o=0, level 0, p_Empty_o=1, p_Full_o=0, p_Over_o=0, and pointers and shift register cleared.
REQ-035 Reset asserted mid-frame SHALL abort the frame immediately, with Tx_o=1 asynchronously.

Verification
REQ-036 Scenario: write 0x55, even parity, little-end, enabled -> Tx_o sequence 0,1,0,1,0,1,0,1,0,0(parity),1, each lasting one BaudSig_i period, then IDLE.
REQ-037 Scenario: write 0xA3 with p_BigEnd_i=1, odd parity -> bits 1,0,1,0,0,0,1,1, parity 1, stop 1.
REQ-038 Scenario: write 3 bytes, parity disabled -> three 10-bit frames back-to-back with no idle high between stop and start; p_Empty_o=1 after the third pop.
REQ-039 Scenario: p_Enable_i=0, write DEPTH+1 bytes -> p_Full_o=1, p_Over_o=1, level=DEPTH; then n_Clr_i pulse -> level 0, p_Over_o=0, Tx_o stays 1.
REQ-040 Scenario: rst pulse during DATABITS -> Tx_o=1 and State_o=5'b00001 immediately; the next write transmits normally.
REQ-041 Scenario: write to a full FIFO on the same cycle as a STOPBIT->STARTBIT pop -> byte dropped, p_Over_o=1, level=DEPTH-1.
